// File: rtl/axi_if_ct_rd_burst_split.sv
// axi_if_ct_rd_burst_split
// Read-command front end for the CT-area AXI4 master port. Splits a
// (start address, word count) command into INCR bursts that stay inside one
// DDR page and never exceed AXI4_WORD_MAX words. It issues the bursts on AR
// with an outstanding-burst limit, and forwards R beats with a
// command-level last flag.
// Optional feature: define AXI_IF_CT_RD_RRESP_CHECK_EN to enable the sticky
// rresp error flag. Otherwise error is tied low and rresp is ignored.
module axi_if_ct_rd_burst_split #(
    parameter int unsigned AXI4_ADD_W      = 64,
    parameter int unsigned AXI4_DATA_W     = 512,
    parameter int unsigned PAGE_BYTES      = 4096,
    parameter int unsigned CMD_WORD_W      = 16,
    parameter int unsigned OUTSTANDING_MAX = 16
) (
    input  logic                   clk,
    input  logic                   a_rst_n,
    input  logic [AXI4_ADD_W-1:0]  cmd_add,
    input  logic [CMD_WORD_W-1:0]  cmd_word_nb,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    output logic                   m_axi4_arid,
    output logic [AXI4_ADD_W-1:0]  m_axi4_araddr,
    output logic [7:0]             m_axi4_arlen,
    output logic [2:0]             m_axi4_arsize,
    output logic [1:0]             m_axi4_arburst,
    output logic                   m_axi4_arvalid,
    input  logic                   m_axi4_arready,
    input  logic                   m_axi4_rid,
    input  logic [AXI4_DATA_W-1:0] m_axi4_rdata,
    input  logic [1:0]             m_axi4_rresp,
    input  logic                   m_axi4_rlast,
    input  logic                   m_axi4_rvalid,
    output logic                   m_axi4_rready,
    output logic [AXI4_DATA_W-1:0] out_data,
    output logic                   out_last,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   error
);

    localparam int unsigned AXI4_DATA_BYTES   = AXI4_DATA_W / 8;
    localparam int unsigned AXI4_DATA_BYTES_W = $clog2(AXI4_DATA_BYTES);
    localparam int unsigned PAGE_W            = $clog2(PAGE_BYTES);
    localparam int unsigned PAGE_AXI4_DATA    = PAGE_BYTES / AXI4_DATA_BYTES;
    localparam int unsigned AXI4_WORD_MAX     = (PAGE_AXI4_DATA < 256) ? PAGE_AXI4_DATA : 256;
    localparam int unsigned OUTST_W           = $clog2(OUTSTANDING_MAX + 1);
    localparam logic [OUTST_W-1:0] OUTST_LIM  = OUTST_W'(OUTSTANDING_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [AXI4_ADD_W-1:0]  add_q, add_d;
    logic [CMD_WORD_W-1:0]  ar_rem_q, ar_rem_d;
    logic [CMD_WORD_W-1:0]  r_rem_q, r_rem_d;
    logic [OUTST_W-1:0]     outst_q, outst_d;
    logic                   arvalid_q, arvalid_d;
    logic [AXI4_ADD_W-1:0]  araddr_q, araddr_d;
    logic [7:0]             arlen_q, arlen_d;
    logic [CMD_WORD_W-1:0]  words_d;
    logic [CMD_WORD_W-1:0]  ar_words;
    logic                   ar_hs;
    logic                   r_active;
    logic                   r_hs;
    logic                   rlast_hs;

    // Words in the next burst: limited by remaining words, room left in the
    // current page and the maximum burst length.
    function automatic logic [CMD_WORD_W-1:0] burst_words(
        input logic [AXI4_ADD_W-1:0] addr,
        input logic [CMD_WORD_W-1:0] rem
    );
        logic [31:0] to_page;
        logic [31:0] words;
        to_page = PAGE_AXI4_DATA - 32'(addr[PAGE_W-1:AXI4_DATA_BYTES_W]);
        words   = 32'(rem);
        if (to_page < words) words = to_page;
        if (AXI4_WORD_MAX < words) words = AXI4_WORD_MAX;
        return words[CMD_WORD_W-1:0];
    endfunction

    assign ar_hs    = arvalid_q && m_axi4_arready;
    assign r_active = (state_q != IDLE);
    assign r_hs     = m_axi4_rvalid && m_axi4_rready;
    assign rlast_hs = r_hs && m_axi4_rlast;
    // The burst being handshaken was sized when its payload was registered,
    // so its length is recovered from arlen_q instead of re-running the split.
    assign ar_words = CMD_WORD_W'(arlen_q) + 1'b1;

    assign cmd_rdy        = (state_q == IDLE);
    assign m_axi4_arid    = 1'b0;
    assign m_axi4_araddr  = araddr_q;
    assign m_axi4_arlen   = arlen_q;
    assign m_axi4_arsize  = 3'(AXI4_DATA_BYTES_W);
    assign m_axi4_arburst = 2'b01;
    assign m_axi4_arvalid = arvalid_q;

    assign out_data      = m_axi4_rdata;
    assign out_vld       = m_axi4_rvalid && r_active;
    assign m_axi4_rready = out_rdy && r_active;
    assign out_last      = (r_rem_q == CMD_WORD_W'(1));

    // Next-state logic: command latch, burst split, outstanding count and
    // the registered AR payload for the following cycle.
    always_comb begin
        state_d   = state_q;
        add_d     = add_q;
        ar_rem_d  = ar_rem_q;
        r_rem_d   = r_rem_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        outst_d   = outst_q + OUTST_W'(ar_hs) - OUTST_W'(rlast_hs);

        unique case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    state_d  = ISSUE;
                    add_d    = cmd_add;
                    ar_rem_d = cmd_word_nb;
                    r_rem_d  = cmd_word_nb;
                end
            end
            ISSUE: begin
                if (ar_hs) begin
                    add_d    = add_q + (AXI4_ADD_W'(ar_words) << AXI4_DATA_BYTES_W);
                    ar_rem_d = ar_rem_q - ar_words;
                    if (ar_rem_d == '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
            end
            default: state_d = IDLE;
        endcase

        if (r_hs) begin
            r_rem_d = r_rem_q - 1'b1;
            if (r_rem_q == CMD_WORD_W'(1)) state_d = IDLE;
        end

        // Payload only changes when a new burst is presented, so it is held
        // stable while arvalid waits for arready.
        words_d   = burst_words(add_d, ar_rem_d);
        arvalid_d = (state_d == ISSUE) && (ar_rem_d != '0) && (outst_d < OUTST_LIM);
        if (arvalid_d) begin
            araddr_d = add_d;
            arlen_d  = 8'(words_d - 1'b1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q   <= IDLE;
            add_q     <= '0;
            ar_rem_q  <= '0;
            r_rem_q   <= '0;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            ar_rem_q  <= ar_rem_d;
            r_rem_q   <= r_rem_d;
            outst_q   <= outst_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
        end
    end

`ifdef AXI_IF_CT_RD_RRESP_CHECK_EN
    logic error_q;
    logic unused_rid;

    assign unused_rid = m_axi4_rid;
    assign error      = error_q;

    // Sticky error on any accepted beat with a non-OKAY response.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            error_q <= 1'b0;
        end else if (r_hs && (m_axi4_rresp != 2'b00)) begin
            error_q <= 1'b1;
        end
    end
`else
    logic unused_r;

    assign unused_r = ^{m_axi4_rid, m_axi4_rresp};
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_if_ct_rd_burst_split.sv
// Directed bench for axi_if_ct_rd_burst_split: AR acceptor, R beat source and
// output consumer around the DUT, with hand-computed burst lists.
`timescale 1ns/1ps
module tb_axi_if_ct_rd_burst_split;

    localparam int unsigned DW = 512;

`ifdef AXI_IF_CT_RD_RRESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   cmd_add;
    logic [15:0]   cmd_word_nb;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic          arid;
    logic [63:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic          rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_vld;
    logic          out_rdy;
    logic          error;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0]  ar_log_addr[$];
    logic [7:0]   ar_log_len[$];
    logic [63:0]  exp_addr[$];
    logic [7:0]   exp_len[$];
    int unsigned  pend[$];
    bit           r_en;
    bit           bad_resp;
    int unsigned  out_beats;
    int unsigned  last_cnt;
    int unsigned  last_at;
    logic         rdy_at_last;
    logic [31:0]  rdata_cnt = '0;
    logic [31:0]  exp_data  = '0;

    always #5 clk = ~clk;

    axi_if_ct_rd_burst_split #(
        .OUTSTANDING_MAX(2)
    ) dut (
        .clk            (clk),
        .a_rst_n        (rst_n),
        .cmd_add        (cmd_add),
        .cmd_word_nb    (cmd_word_nb),
        .cmd_vld        (cmd_vld),
        .cmd_rdy        (cmd_rdy),
        .m_axi4_arid    (arid),
        .m_axi4_araddr  (araddr),
        .m_axi4_arlen   (arlen),
        .m_axi4_arsize  (arsize),
        .m_axi4_arburst (arburst),
        .m_axi4_arvalid (arvalid),
        .m_axi4_arready (arready),
        .m_axi4_rid     (rid),
        .m_axi4_rdata   (rdata),
        .m_axi4_rresp   (rresp),
        .m_axi4_rlast   (rlast),
        .m_axi4_rvalid  (rvalid),
        .m_axi4_rready  (rready),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .error          (error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // AR acceptor log: records every handshaken burst and queues its beats.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && arvalid && arready) begin
                ar_log_addr.push_back(araddr);
                ar_log_len.push_back(arlen);
                pend.push_back(int'(arlen) + 1);
            end
        end
    end

    // Output consumer: checks forwarded data and records where out_last fell.
    initial begin
        forever begin
            @(negedge clk);
            if (out_vld && out_rdy) begin
                out_beats++;
                chk("out_data", {out_data[DW-1 -: 32], out_data[31:0]}, {exp_data, exp_data});
                exp_data++;
                if (out_last) begin
                    last_cnt++;
                    last_at     = out_beats;
                    rdy_at_last = cmd_rdy;
                end
            end
        end
    end

    // R beat source: serves accepted bursts in order while r_en is set.
    initial begin
        int unsigned beat;
        int unsigned tmp;
        bit          hs;
        beat = 0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            hs = rvalid && rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend.delete();
                beat = 0;
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end else begin
                if (hs) begin
                    rdata_cnt++;
                    rresp = 2'b00;
                    if (rlast) begin
                        tmp  = pend.pop_front();
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                if (r_en && pend.size() != 0) begin
                    rvalid = 1'b1;
                    rdata  = {16{rdata_cnt}};
                    rlast  = (beat == pend[0] - 1);
                    if (bad_resp) begin
                        rresp    = 2'b10;
                        bad_resp = 1'b0;
                    end
                end else begin
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                end
            end
        end
    end

    task automatic start_cmd(input logic [63:0] addr, input logic [15:0] nb);
        int unsigned t;
        ar_log_addr.delete();
        ar_log_len.delete();
        out_beats   = 0;
        last_cnt    = 0;
        last_at     = 0;
        rdy_at_last = 1'bx;
        t = 0;
        while (!cmd_rdy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("cmd_rdy_wait", 64'(cmd_rdy), 64'd1);
        cmd_add     = addr;
        cmd_word_nb = nb;
        cmd_vld     = 1'b1;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        chk("cmd_rdy_busy", 64'(cmd_rdy), 64'd0);
        chk("arvalid_n1", 64'(arvalid), 64'd1);
        chk("araddr_n1", araddr, addr);
    endtask

    task automatic finish_cmd(input int unsigned nb);
        int unsigned t;
        t = 0;
        while (out_beats < nb && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("beats", 64'(out_beats), 64'(nb));
        chk("last_cnt", 64'(last_cnt), 64'd1);
        chk("last_at", 64'(last_at), 64'(nb));
        chk("rdy_at_last", 64'(rdy_at_last), 64'd0);
        chk("cmd_rdy_after", 64'(cmd_rdy), 64'd1);
        chk("ar_count", 64'(ar_log_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < ar_log_addr.size(); i++) begin
            chk("ar_addr", ar_log_addr[i], exp_addr[i]);
            chk("ar_len", 64'(ar_log_len[i]), 64'(exp_len[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        bit          seen;
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_add = '0; cmd_word_nb = '0;
        arready = 1'b1; out_rdy = 1'b1; r_en = 1'b1; bad_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_araddr", araddr, 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("arsize", 64'(arsize), 64'd6);
        chk("arburst", 64'(arburst), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single burst.
        exp_addr = {64'h0};  exp_len = {8'd3};
        start_cmd(64'h0, 16'd4);
        finish_cmd(4);

        // Page crossing after one word.
        exp_addr = {64'hFC0, 64'h1000};  exp_len = {8'd0, 8'd1};
        start_cmd(64'hFC0, 16'd3);
        finish_cmd(3);

        // Max-length burst followed by remainder.
        exp_addr = {64'h0, 64'h1000};  exp_len = {8'd63, 8'd35};
        start_cmd(64'h0, 16'd100);
        finish_cmd(100);

        // Outstanding limit of 2 with R held off.
        exp_addr = {64'h0, 64'h1000, 64'h2000};  exp_len = {8'd63, 8'd63, 8'd63};
        @(negedge clk); r_en = 1'b0;
        start_cmd(64'h0, 16'd192);
        repeat (10) @(posedge clk);
        #1;
        chk("ar_cnt_limited", 64'(ar_log_addr.size()), 64'd2);
        chk("arvalid_blocked", 64'(arvalid), 64'd0);
        @(negedge clk); r_en = 1'b1;
        t = 0; seen = 1'b0;
        while (!seen && t < 500) begin
            @(negedge clk);
            if (rvalid && rready && rlast) begin
                seen = 1'b1;
                chk("arvalid_at_rlast", 64'(arvalid), 64'd0);
            end
            t++;
        end
        chk("rlast_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        chk("arvalid_after_rlast", 64'(arvalid), 64'd1);
        chk("araddr_after_rlast", araddr, 64'h2000);
        chk("arlen_after_rlast", 64'(arlen), 64'd63);
        finish_cmd(192);

        // arready held low for 10 cycles.
        exp_addr = {64'h40};  exp_len = {8'd7};
        arready = 1'b0;
        start_cmd(64'h40, 16'd8);
        for (int i = 0; i < 10; i++) begin
            chk("arvalid_hold", 64'(arvalid), 64'd1);
            chk("araddr_hold", araddr, 64'h40);
            chk("arlen_hold", 64'(arlen), 64'd7);
            @(posedge clk); #1;
        end
        arready = 1'b1;
        @(posedge clk); #1;
        chk("ar_issued_once", 64'(ar_log_addr.size()), 64'd1);
        chk("arvalid_done", 64'(arvalid), 64'd0);
        finish_cmd(8);

        // Error response on the first beat.
        exp_addr = {64'h80};  exp_len = {8'd1};
        @(negedge clk); r_en = 1'b0;
        start_cmd(64'h80, 16'd2);
        @(negedge clk); bad_resp = 1'b1; r_en = 1'b1;
        t = 0; seen = 1'b0;
        while (!seen && t < 50) begin
            @(negedge clk);
            if (rvalid && rready) begin
                seen = 1'b1;
                chk("err_before", 64'(error), 64'd0);
            end
            t++;
        end
        chk("bad_beat_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        chk("err_next", 64'(error), 64'(EXP_ERR));
        finish_cmd(2);
        chk("err_sticky", 64'(error), 64'(EXP_ERR));

        // Reset in the middle of a command.
        exp_addr = {64'h0};  exp_len = {8'd7};
        start_cmd(64'h0, 16'd8);
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("pre_rst_vld", 64'(out_vld), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("mr_arvalid", 64'(arvalid), 64'd0);
        chk("mr_rready", 64'(rready), 64'd0);
        chk("mr_out_vld", 64'(out_vld), 64'd0);
        chk("mr_error", 64'(error), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-word command after reset.
        exp_addr = {64'h2000};  exp_len = {8'd0};
        start_cmd(64'h2000, 16'd1);
        finish_cmd(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_if_ct_rd_burst_split.md
# axi_if_ct_rd_burst_split

Read-command front end for the CT-area AXI4 master port. Accepts a (start address, word count) read command, splits it into INCR bursts that never cross a DDR page and never exceed the maximum burst length, and issues them on the AR channel. It returns the R beats to a downstream consumer with a command-level last flag and an outstanding-burst limit. Its AR/R channels use the CT-area AXI4 channel structures and parameters.

## Interface
- AXI4_ADD_W, 64, address width
- AXI4_DATA_W, 512, data width; AXI4_DATA_BYTES = AXI4_DATA_W/8, AXI4_DATA_BYTES_W = log2 of that
- PAGE_BYTES, 4096, DDR page size; PAGE_AXI4_DATA = PAGE_BYTES/AXI4_DATA_BYTES
- AXI4_WORD_MAX, min(PAGE_AXI4_DATA,256), maximum words per burst
- CMD_WORD_W, 16, width of command word count
- OUTSTANDING_MAX, 16, maximum bursts issued but not yet completed by rlast
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- cmd_add  in  AXI4_ADD_W  start byte address; aligned to AXI4_DATA_BYTES
- cmd_word_nb  in  CMD_WORD_W  number of AXI words to read; ≥1
- cmd_vld / cmd_rdy  in/out  1  command handshake
- m_axi4_arid/araddr/arlen/arsize/arburst  out  1/64/8/3/2  AR payload
- m_axi4_arvalid / m_axi4_arready  out/in  1  AR handshake
- m_axi4_rid/rdata/rresp/rlast  in  1/AXI4_DATA_W/2/1  R payload
- m_axi4_rvalid / m_axi4_rready  in/out  1  R handshake
- out_data  out  AXI4_DATA_W  forwarded rdata
- out_last  out  1  last word of current command
- out_vld / out_rdy  out/in  1  output handshake
- error  out  1  sticky response error (see Configuration)

## Operation
- States: IDLE, ISSUE, DRAIN. cmd_rdy = (state==IDLE).
- IDLE: on cmd_vld&&cmd_rdy, latch add_q=cmd_add, ar_rem=cmd_word_nb, r_rem=cmd_word_nb; go to ISSUE.
- Burst size: to_page = PAGE_AXI4_DATA − add_q[log2(PAGE_BYTES)-1:AXI4_DATA_BYTES_W]; words = min(ar_rem, to_page, AXI4_WORD_MAX); arlen = words−1.
- AR constants: arid=0, arsize=AXI4_DATA_BYTES_W, arburst=2'b01 (INCR).
- On AR handshake: add_q += words*AXI4_DATA_BYTES; ar_rem −= words; outstanding++. When ar_rem reaches 0, go to DRAIN.
- On each accepted R beat with rlast: outstanding−−. If an AR handshake and a rlast beat occur in the same cycle, outstanding is unchanged.
- arvalid is asserted only when in ISSUE and outstanding < OUTSTANDING_MAX.
- R path is combinational: out_data=rdata, out_vld=rvalid&&(state!=IDLE), m_axi4_rready=out_rdy&&(state!=IDLE). out_last=(r_rem==1).
- Each accepted beat decrements r_rem. The beat with r_rem==1 returns the FSM to IDLE from either ISSUE or DRAIN.
- Address arithmetic is done at full AXI4_ADD_W width; wrap above 2^64 is undefined (cmd_add+bytes must not overflow).

## Timing
- Reset values: cmd_rdy=1 (IDLE), arvalid=0, AR payload=0, error=0, outstanding=0.
- Command accepted at edge N → arvalid=1 in cycle N+1 with the first burst.
- arvalid is registered. Payload is stable while arvalid&&!arready. Back-to-back bursts are issued one per cycle when arready=1.
- The R→out path has zero latency.
- A new command is accepted no earlier than the cycle after the last out beat handshake.
- Reset mid-operation clears all state immediately. rready=0 in IDLE. The bench must not deliver R beats for pre-reset bursts.

## Configuration
- AXI_IF_CT_RD_RRESP_CHECK_EN defined: error sets to 1 on any accepted beat with rresp≠2'b00 and holds until reset. Data is still forwarded.
- Not defined: error is tied to 0 and rresp is ignored.

## Test plan
- cmd_add=0x0, nb=4 → one AR: araddr=0x0, arlen=3. 4 out beats, out_last on the 4th. cmd_rdy returns to 1 the next cycle.
- cmd_add=0xFC0, nb=3 (512-bit, 4 KiB page) → AR araddr=0xFC0 arlen=0, then AR araddr=0x1000 arlen=1.
- cmd_add=0x0, nb=100 → AR araddr=0x0 arlen=63, then AR araddr=0x1000 arlen=35. out_last only on beat 100.
- OUTSTANDING_MAX=2, nb=192 at 0x0, arready=1, R held off → exactly 2 ARs issued. The 3rd AR appears the cycle after the first rlast is accepted.
- arready=0 for 10 cycles after the first arvalid → arvalid stays 1 and araddr/arlen stay unchanged; the burst is issued on the first arready=1.
- Macro defined, one beat with rresp=2'b10 → error=1 from the next cycle, sticky. Macro undefined, same stimulus → error=0.
